// File: rtl/loop_sequencer.sv
// Microcode sequencer: fetches instruction words, dispatches channel start pulses, runs nested hardware loops.
// Optional build macro SEQ_LOOP_ADDR_RESTORE_EN: loop entries also save RADDRX and restore it on each repeat.
module loop_sequencer #(
    parameter int IW         = 256,
    parameter int PCW        = 16,
    parameter int NCH        = 3,
    parameter int LOOP_DEPTH = 3,
    parameter int CW         = 8,
    parameter int AW         = 16
) (
    input  logic           CLK,
    input  logic           RSTL,
    input  logic           PURGE,
    input  logic           START,
    input  logic [IW-1:0]  QI,
    output logic [PCW-1:0] RADDRI,
    output logic           RCEBI,
    // CH_REQ is a one-cycle start pulse with CH_ARG alongside; a channel accepts it unconditionally
    // and holds CH_BUSY high from the following cycle until it has finished.
    output logic [NCH-1:0] CH_REQ,
    output logic [CW-1:0]  CH_ARG,
    input  logic [NCH-1:0] CH_BUSY,
    output logic [AW-1:0]  RADDRX,
    output logic           SEQ_BUSY,
    output logic           SEQ_FIN,
    output logic           LOOP_ERR,
    output logic [2:0]     DBG_STATE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] OP_DISPATCH   = 4'd1;
    localparam logic [3:0] OP_LOOP_BEGIN = 4'd2;
    localparam logic [3:0] OP_LOOP_END   = 4'd3;
    localparam logic [3:0] OP_HALT       = 4'd4;

    localparam int SPW  = $clog2(LOOP_DEPTH + 1);
    localparam int IXW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam int QTOP = AW + CW + NCH + 6;
    localparam logic [SPW-1:0] SP_FULL = SPW'(LOOP_DEPTH);

    logic [2:0]     state;
    logic [PCW-1:0] pc;
    logic [PCW-1:0] pc_inc;
    logic [SPW-1:0] sp;
    logic           drain_first;
    logic [NCH-1:0] mask_q;
    logic [1:0]     amode_q;
    logic [AW-1:0]  aval_q;

    logic [PCW-1:0] stk_pc  [LOOP_DEPTH];
    logic [CW-1:0]  stk_cnt [LOOP_DEPTH];
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
    logic [AW-1:0]  stk_addr [LOOP_DEPTH];
`endif

    logic [3:0]     op;
    logic [CW-1:0]  arg;
    logic [NCH-1:0] mask;
    logic           nb;
    logic [1:0]     amode;
    logic [AW-1:0]  aval;
    logic           unused_qi;

    assign op    = QI[3:0];
    assign arg   = QI[CW+3:4];
    assign mask  = QI[CW+NCH+3:CW+4];
    assign nb    = QI[CW+NCH+4];
    assign amode = QI[CW+NCH+6:CW+NCH+5];
    assign aval  = QI[QTOP:CW+NCH+7];

    generate
        if (IW > QTOP + 1) begin : g_spare
            assign unused_qi = ^QI[IW-1:QTOP+1];
        end else begin : g_nospare
            assign unused_qi = 1'b0;
        end
    endgenerate

    function automatic logic [AW-1:0] addr_step(input logic [AW-1:0] x, input logic [1:0] mode,
                                                input logic [AW-1:0] v);
        case (mode)
            2'b01:   return x + v;
            2'b10:   return x - v;
            2'b11:   return v;
            default: return x;
        endcase
    endfunction

    logic [IXW-1:0] top_ix;
    logic [IXW-1:0] push_ix;
    logic [CW-1:0]  top_cnt;
    logic [CW-1:0]  init_cnt;
    logic           stk_full;
    logic           stk_empty;
    logic           loop_again;
    logic           busy_hit;
    logic [AW-1:0]  x_exec;
    logic [AW-1:0]  x_drain;

    always_comb begin
        pc_inc     = pc + 1'b1;
        push_ix    = IXW'(sp);
        top_ix     = IXW'(sp - 1'b1);
        top_cnt    = stk_cnt[top_ix];
        init_cnt   = (arg == '0) ? CW'(1) : arg;
        stk_full   = (sp == SP_FULL);
        stk_empty  = (sp == '0);
        loop_again = (top_cnt > CW'(1));
        busy_hit   = |(CH_BUSY & mask);
        x_exec     = addr_step(RADDRX, amode, aval);
        x_drain    = addr_step(RADDRX, amode_q, aval_q);
    end

    assign RADDRI    = {pc[PCW-2:0], 1'b0};
    assign RCEBI     = (state != S_FETCH);
    assign SEQ_BUSY  = (state != S_IDLE);
    assign SEQ_FIN   = (state == S_DONE);
    assign DBG_STATE = state;

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            state       <= S_IDLE;
            pc          <= '0;
            sp          <= '0;
            drain_first <= 1'b0;
            mask_q      <= '0;
            amode_q     <= '0;
            aval_q      <= '0;
            CH_REQ      <= '0;
            CH_ARG      <= '0;
            RADDRX      <= '0;
            LOOP_ERR    <= 1'b0;
        end else begin
            CH_REQ <= '0;
            if (PURGE) begin
                state       <= S_IDLE;
                pc          <= '0;
                sp          <= '0;
                drain_first <= 1'b0;
                RADDRX      <= '0;
                LOOP_ERR    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START) begin
                            pc    <= '0;
                            sp    <= '0;
                            state <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_EXEC;
                    S_EXEC: begin
                        case (op)
                            OP_DISPATCH: begin
                                if (mask == '0) begin
                                    pc     <= pc_inc;
                                    RADDRX <= x_exec;
                                    state  <= S_FETCH;
                                end else if (!busy_hit) begin
                                    CH_REQ <= mask;
                                    CH_ARG <= arg;
                                    if (nb) begin
                                        pc     <= pc_inc;
                                        RADDRX <= x_exec;
                                        state  <= S_FETCH;
                                    end else begin
                                        // Address update is deferred until the drain completes.
                                        mask_q      <= mask;
                                        amode_q     <= amode;
                                        aval_q      <= aval;
                                        drain_first <= 1'b1;
                                        state       <= S_DRAIN;
                                    end
                                end
                            end
                            OP_LOOP_BEGIN: begin
                                if (stk_full) begin
                                    LOOP_ERR <= 1'b1;
                                    state    <= S_DONE;
                                end else begin
                                    sp     <= sp + 1'b1;
                                    pc     <= pc_inc;
                                    RADDRX <= x_exec;
                                    state  <= S_FETCH;
                                end
                            end
                            OP_LOOP_END: begin
                                if (stk_empty) begin
                                    LOOP_ERR <= 1'b1;
                                    state    <= S_DONE;
                                end else if (loop_again) begin
                                    pc     <= stk_pc[top_ix];
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
                                    RADDRX <= stk_addr[top_ix];
`else
                                    RADDRX <= x_exec;
`endif
                                    state  <= S_FETCH;
                                end else begin
                                    sp     <= sp - 1'b1;
                                    pc     <= pc_inc;
                                    RADDRX <= x_exec;
                                    state  <= S_FETCH;
                                end
                            end
                            OP_HALT: begin
                                RADDRX <= x_exec;
                                state  <= S_DONE;
                            end
                            default: begin
                                pc     <= pc_inc;
                                RADDRX <= x_exec;
                                state  <= S_FETCH;
                            end
                        endcase
                    end
                    S_DRAIN: begin
                        // Busy from the channels only becomes visible one cycle after the request.
                        if (drain_first) begin
                            drain_first <= 1'b0;
                        end else if ((CH_BUSY & mask_q) == '0) begin
                            pc     <= pc_inc;
                            RADDRX <= x_drain;
                            state  <= S_FETCH;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state == S_EXEC && !PURGE) begin
            if (op == OP_LOOP_BEGIN && !stk_full) begin
                stk_pc[push_ix]   <= pc_inc;
                stk_cnt[push_ix]  <= init_cnt;
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
                stk_addr[push_ix] <= x_exec;
`endif
            end else if (op == OP_LOOP_END && !stk_empty && loop_again) begin
                stk_cnt[top_ix] <= top_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: directed timing scenarios plus random programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_loop_sequencer;
    localparam int IW = 256, PCW = 16, NCH = 3, LOOP_DEPTH = 3, CW = 8, AW = 16;
    localparam int W = NCH + CW;
    localparam int MEMW = 64;
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
    localparam logic [AW-1:0] NEST_X = 16'd4;
`else
    localparam logic [AW-1:0] NEST_X = 16'd24;
`endif

    logic           CLK = 1'b0;
    logic           RSTL = 1'b0;
    logic           PURGE = 1'b0;
    logic           START = 1'b0;
    logic [IW-1:0]  QI = '0;
    logic [PCW-1:0] RADDRI;
    logic           RCEBI;
    logic [NCH-1:0] CH_REQ;
    logic [CW-1:0]  CH_ARG;
    logic [NCH-1:0] CH_BUSY;
    logic [AW-1:0]  RADDRX;
    logic           SEQ_BUSY, SEQ_FIN, LOOP_ERR;
    logic [2:0]     DBG_STATE;

    int checks = 0;
    int failures = 0;

    logic [IW-1:0]  mem [MEMW];
    int             busy_len [NCH];
    int             busy_cnt [NCH];

    logic [W-1:0]   exp_q[$];
    logic [AW-1:0]  exp_x;
    logic           exp_err;
    logic [PCW-1:0] exp_pc;

    logic [W-1:0]   obs_q[$];
    int             req_cyc[$];
    logic [NCH-1:0] req_busy[$];
    int             fetch_first [MEMW];
    int             fin_cnt;
    logic           busy_after_fin;
    bit             timed_out;

    always #5 CLK = ~CLK;

    loop_sequencer dut (
        .CLK(CLK), .RSTL(RSTL), .PURGE(PURGE), .START(START), .QI(QI),
        .RADDRI(RADDRI), .RCEBI(RCEBI), .CH_REQ(CH_REQ), .CH_ARG(CH_ARG), .CH_BUSY(CH_BUSY),
        .RADDRX(RADDRX), .SEQ_BUSY(SEQ_BUSY), .SEQ_FIN(SEQ_FIN), .LOOP_ERR(LOOP_ERR),
        .DBG_STATE(DBG_STATE)
    );

    // Instruction SRAM: data appears the cycle after an enabled read and holds otherwise.
    always @(posedge CLK) if (!RCEBI) QI <= mem[RADDRI[6:1]];

    // Channels: busy for busy_len cycles starting the cycle after their request pulse.
    always @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            for (int c = 0; c < NCH; c++) busy_cnt[c] <= 0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (CH_REQ[c]) busy_cnt[c] <= busy_len[c];
                else if (busy_cnt[c] > 0) busy_cnt[c] <= busy_cnt[c] - 1;
            end
        end
    end

    always_comb begin
        CH_BUSY = '0;
        for (int c = 0; c < NCH; c++) CH_BUSY[c] = (busy_cnt[c] != 0);
    end

    function automatic logic [IW-1:0] mk(input int op, input int arg, input int mask, input bit nb,
                                         input int amode, input int aval);
        logic [IW-1:0] w;
        w = '0;
        w[3:0] = op[3:0];
        w[CW+3:4] = arg[CW-1:0];
        w[CW+NCH+3:CW+4] = mask[NCH-1:0];
        w[CW+NCH+4] = nb;
        w[CW+NCH+6:CW+NCH+5] = amode[1:0];
        w[AW+CW+NCH+6:CW+NCH+7] = aval[AW-1:0];
        return w;
    endfunction

    function automatic logic [AW-1:0] am_step(input logic [AW-1:0] x, input logic [1:0] m, input logic [AW-1:0] v);
        if (m == 2'd1) return x + v;
        if (m == 2'd2) return x - v;
        if (m == 2'd3) return v;
        return x;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < MEMW; i++) mem[i] = mk(4, 0, 0, 0, 0, 0);
    endtask

    // Instruction-level interpreter: what the program should dispatch and where it ends up.
    task automatic model_run();
        int pc, sp, steps, op, arg;
        bit run;
        int st_pc [LOOP_DEPTH];
        int st_cnt [LOOP_DEPTH];
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
        logic [AW-1:0] st_x [LOOP_DEPTH];
`endif
        logic [AW-1:0] x, av;
        logic [IW-1:0] w;
        logic [NCH-1:0] mask;
        logic [1:0] m;
        exp_q.delete();
        pc = 0; sp = 0; x = '0; exp_err = 1'b0; run = 1; steps = 0;
        while (run && steps < 20000) begin
            steps++;
            w = mem[pc % MEMW];
            op = int'(w[3:0]);
            arg = int'(w[CW+3:4]);
            mask = w[CW+NCH+3:CW+4];
            m = w[CW+NCH+6:CW+NCH+5];
            av = w[AW+CW+NCH+6:CW+NCH+7];
            case (op)
                1: begin
                    if (mask != 0) exp_q.push_back({mask, arg[CW-1:0]});
                    x = am_step(x, m, av); pc++;
                end
                2: begin
                    if (sp == LOOP_DEPTH) begin exp_err = 1'b1; run = 0; end
                    else begin
                        x = am_step(x, m, av);
                        st_pc[sp] = pc + 1;
                        st_cnt[sp] = (arg == 0) ? 1 : arg;
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
                        st_x[sp] = x;
`endif
                        sp++; pc++;
                    end
                end
                3: begin
                    if (sp == 0) begin exp_err = 1'b1; run = 0; end
                    else if (st_cnt[sp-1] > 1) begin
                        st_cnt[sp-1]--;
                        pc = st_pc[sp-1];
`ifdef SEQ_LOOP_ADDR_RESTORE_EN
                        x = st_x[sp-1];
`else
                        x = am_step(x, m, av);
`endif
                    end else begin
                        sp--; x = am_step(x, m, av); pc++;
                    end
                end
                4: begin x = am_step(x, m, av); run = 0; end
                default: begin x = am_step(x, m, av); pc++; end
            endcase
            pc = pc % (1 << PCW);
        end
        exp_x = x;
        exp_pc = PCW'(pc);
    endtask

    task automatic do_purge(input int settle);
        @(negedge CLK); PURGE = 1'b1;
        @(negedge CLK); PURGE = 1'b0;
        repeat (settle) @(negedge CLK);
    endtask

    // Starts the loaded program and traces it cycle by cycle until one cycle after SEQ_FIN.
    task automatic run_prog(input int max_cyc);
        bit done;
        int fin_cyc;
        obs_q.delete(); req_cyc.delete(); req_busy.delete();
        for (int i = 0; i < MEMW; i++) fetch_first[i] = -1;
        fin_cnt = 0; fin_cyc = -10; done = 0; busy_after_fin = 1'bx;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        for (int cyc = 1; cyc <= max_cyc && !done; cyc++) begin
            if (cyc > 1) @(negedge CLK);
            if (CH_REQ != '0) begin
                obs_q.push_back({CH_REQ, CH_ARG});
                req_cyc.push_back(cyc);
                req_busy.push_back(CH_BUSY);
            end
            if (!RCEBI && fetch_first[RADDRI[6:1]] < 0) fetch_first[RADDRI[6:1]] = cyc;
            if (cyc == fin_cyc + 1) begin busy_after_fin = SEQ_BUSY; done = 1; end
            if (SEQ_FIN) begin fin_cnt++; fin_cyc = cyc; end
        end
        timed_out = !done;
    endtask

    task automatic test_reset();
        RSTL = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (RCEBI !== 1'b1) begin failures++; $display("FAIL reset_rcebi got=%b exp=1", RCEBI); end
        checks++; if (RADDRI !== '0) begin failures++; $display("FAIL reset_raddri got=%0h exp=0", RADDRI); end
        checks++; if (CH_REQ !== '0 || CH_ARG !== '0) begin failures++; $display("FAIL reset_ch got=%b/%0h exp=0/0", CH_REQ, CH_ARG); end
        checks++; if (RADDRX !== '0) begin failures++; $display("FAIL reset_raddrx got=%0h exp=0", RADDRX); end
        checks++; if ({SEQ_BUSY, SEQ_FIN, LOOP_ERR} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {SEQ_BUSY, SEQ_FIN, LOOP_ERR}); end
        RSTL = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (SEQ_BUSY !== 1'b0 || RCEBI !== 1'b1) begin failures++; $display("FAIL reset_idle busy=%b rcebi=%b exp=0/1", SEQ_BUSY, RCEBI); end
    endtask

    task automatic test_drain();
        do_purge(25);
        clear_mem();
        busy_len[0] = 4;
        mem[0] = mk(0, 0, 0, 0, 0, 0);
        mem[1] = mk(1, 5, 1, 0, 0, 0);
        mem[2] = mk(4, 0, 0, 0, 0, 0);
        run_prog(200);
        checks++; if (timed_out) begin failures++; $display("FAIL drain_timeout got=timeout exp=fin"); end
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL drain_req_count got=%0d exp=1", obs_q.size()); end
        else if (obs_q[0] !== {3'b001, 8'd5}) begin failures++; $display("FAIL drain_req got=%0h exp=%0h", obs_q[0], {3'b001, 8'd5}); end
        else begin
            checks++;
            if (fetch_first[2] != req_cyc[0] + 6) begin failures++; $display("FAIL drain_fetch_time got=%0d exp=%0d", fetch_first[2], req_cyc[0] + 6); end
        end
        checks++; if (fin_cnt != 1) begin failures++; $display("FAIL drain_fin_count got=%0d exp=1", fin_cnt); end
        checks++; if (busy_after_fin !== 1'b0) begin failures++; $display("FAIL drain_busy_after_fin got=%b exp=0", busy_after_fin); end
    endtask

    task automatic test_nonblocking();
        do_purge(25);
        clear_mem();
        busy_len[0] = 10; busy_len[1] = 2;
        mem[0] = mk(1, 1, 1, 1, 0, 0);
        mem[1] = mk(1, 2, 2, 1, 0, 0);
        mem[2] = mk(1, 3, 1, 1, 0, 0);
        mem[3] = mk(4, 0, 0, 0, 0, 0);
        run_prog(300);
        checks++; if (timed_out) begin failures++; $display("FAIL nb_timeout got=timeout exp=fin"); end
        checks++;
        if (obs_q.size() != 3) begin failures++; $display("FAIL nb_req_count got=%0d exp=3", obs_q.size()); end
        else begin
            if (obs_q[0] !== {3'b001, 8'd1} || obs_q[1] !== {3'b010, 8'd2} || obs_q[2] !== {3'b001, 8'd3}) begin
                failures++; $display("FAIL nb_req_values got=%0h,%0h,%0h exp=101,202,103", obs_q[0], obs_q[1], obs_q[2]);
            end
            checks++;
            if (req_busy[1][0] !== 1'b1 || req_cyc[1] != req_cyc[0] + 2) begin
                failures++; $display("FAIL nb_overlap got=busy%b/cyc%0d exp=busy1/cyc%0d", req_busy[1][0], req_cyc[1], req_cyc[0] + 2);
            end
            checks++;
            if (req_cyc[2] != req_cyc[0] + 12) begin failures++; $display("FAIL nb_stall got=%0d exp=%0d", req_cyc[2], req_cyc[0] + 12); end
        end
    endtask

    task automatic test_nested();
        do_purge(25);
        clear_mem();
        for (int c = 0; c < NCH; c++) busy_len[c] = 1;
        mem[0] = mk(2, 3, 0, 0, 0, 0);
        mem[1] = mk(2, 2, 0, 0, 0, 0);
        mem[2] = mk(1, 7, 1, 1, 1, 4);
        mem[3] = mk(3, 0, 0, 0, 0, 0);
        mem[4] = mk(3, 0, 0, 0, 0, 0);
        mem[5] = mk(4, 0, 0, 0, 0, 0);
        model_run();
        run_prog(500);
        checks++; if (timed_out) begin failures++; $display("FAIL nest_timeout got=timeout exp=fin"); end
        checks++;
        if (obs_q.size() != 6) begin failures++; $display("FAIL nest_req_count got=%0d exp=6", obs_q.size()); end
        else if (obs_q != exp_q) begin failures++; $display("FAIL nest_req_values got=%0h exp=%0h", obs_q[0], exp_q[0]); end
        checks++; if (RADDRX !== NEST_X) begin failures++; $display("FAIL nest_raddrx got=%0d exp=%0d", RADDRX, NEST_X); end
        checks++; if (LOOP_ERR !== 1'b0) begin failures++; $display("FAIL nest_loop_err got=%b exp=0", LOOP_ERR); end
    endtask

    task automatic test_zero_count();
        do_purge(25);
        clear_mem();
        mem[0] = mk(2, 0, 0, 0, 0, 0);
        mem[1] = mk(1, 9, 2, 0, 0, 0);
        mem[2] = mk(3, 0, 0, 0, 0, 0);
        mem[3] = mk(4, 0, 0, 0, 0, 0);
        run_prog(200);
        checks++; if (timed_out) begin failures++; $display("FAIL zero_timeout got=timeout exp=fin"); end
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL zero_req_count got=%0d exp=1", obs_q.size()); end
        else if (obs_q[0] !== {3'b010, 8'd9}) begin failures++; $display("FAIL zero_req got=%0h exp=209", obs_q[0]); end
    endtask

    task automatic test_loop_err();
        do_purge(25);
        clear_mem();
        for (int i = 0; i < 4; i++) mem[i] = mk(2, 2, 0, 0, 0, 0);
        mem[4] = mk(4, 0, 0, 0, 0, 0);
        run_prog(200);
        checks++; if (LOOP_ERR !== 1'b1) begin failures++; $display("FAIL overflow_err got=%b exp=1", LOOP_ERR); end
        checks++; if (fin_cnt != 1) begin failures++; $display("FAIL overflow_fin got=%0d exp=1", fin_cnt); end
        checks++; if (RADDRI !== 16'd6) begin failures++; $display("FAIL overflow_pc got=%0d exp=6", RADDRI); end
        do_purge(0);
        checks++; if (LOOP_ERR !== 1'b0) begin failures++; $display("FAIL purge_clears_err got=%b exp=0", LOOP_ERR); end
        clear_mem();
        mem[0] = mk(3, 0, 0, 0, 0, 0);
        run_prog(200);
        checks++; if (LOOP_ERR !== 1'b1 || obs_q.size() != 0) begin failures++; $display("FAIL underflow_err got=%b/%0d exp=1/0", LOOP_ERR, obs_q.size()); end
        checks++; if (fin_cnt != 1) begin failures++; $display("FAIL underflow_fin got=%0d exp=1", fin_cnt); end
    endtask

    task automatic test_purge_drain();
        bit found;
        do_purge(25);
        clear_mem();
        busy_len[0] = 20;
        mem[0] = mk(0, 0, 0, 0, 3, 16'h1234);
        mem[1] = mk(1, 4, 1, 0, 0, 0);
        mem[2] = mk(4, 0, 0, 0, 0, 0);
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK);
            if (CH_REQ != '0) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL purge_req_seen got=none exp=req"); end
        checks++; if (RADDRX !== 16'h1234) begin failures++; $display("FAIL purge_pre_raddrx got=%0h exp=1234", RADDRX); end
        repeat (3) @(negedge CLK);
        PURGE = 1'b1;
        @(negedge CLK); PURGE = 1'b0;
        checks++;
        if (SEQ_BUSY !== 1'b0 || RCEBI !== 1'b1 || RADDRI !== '0 || RADDRX !== '0 || CH_REQ !== '0) begin
            failures++;
            $display("FAIL purge_state got=busy%b rcebi%b raddri%0h raddrx%0h req%b exp=0/1/0/0/0", SEQ_BUSY, RCEBI, RADDRI, RADDRX, CH_REQ);
        end
        busy_len[0] = 3;
        run_prog(400);
        checks++; if (timed_out || fetch_first[0] != 1) begin failures++; $display("FAIL purge_rerun_start got=%0d exp=1", fetch_first[0]); end
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL purge_rerun_count got=%0d exp=1", obs_q.size()); end
        else if (obs_q[0] !== {3'b001, 8'd4}) begin failures++; $display("FAIL purge_rerun_req got=%0h exp=104", obs_q[0]); end
        checks++; if (RADDRX !== 16'h1234) begin failures++; $display("FAIL purge_rerun_raddrx got=%0h exp=1234", RADDRX); end
    endtask

    task automatic test_random();
        int len, r;
        for (int it = 0; it < 16; it++) begin
            do_purge(0);
            clear_mem();
            for (int c = 0; c < NCH; c++) busy_len[c] = $urandom_range(0, 4);
            len = $urandom_range(4, 10);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r <= 3) mem[i] = mk(1, $urandom_range(0, 255), $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
                else if (r <= 5) mem[i] = mk(2, $urandom_range(0, 3), 0, 0, $urandom_range(0, 3), $urandom);
                else if (r <= 7) mem[i] = mk(3, 0, 0, 0, $urandom_range(0, 3), $urandom);
                else if (r == 8) mem[i] = mk(0, 0, 0, 0, $urandom_range(0, 3), $urandom);
                else mem[i] = mk($urandom_range(5, 15), 0, 0, 0, $urandom_range(0, 3), $urandom);
            end
            mem[len] = mk(4, 0, 0, 0, $urandom_range(0, 3), $urandom);
            model_run();
            run_prog(8000);
            checks++; if (timed_out || fin_cnt != 1) begin failures++; $display("FAIL rand%0d_fin got=%0d exp=1", it, fin_cnt); end
            checks++;
            if (obs_q != exp_q) begin failures++; $display("FAIL rand%0d_reqs got=%0d exp=%0d", it, obs_q.size(), exp_q.size()); end
            checks++; if (RADDRX !== exp_x) begin failures++; $display("FAIL rand%0d_raddrx got=%0h exp=%0h", it, RADDRX, exp_x); end
            checks++; if (LOOP_ERR !== exp_err) begin failures++; $display("FAIL rand%0d_loop_err got=%b exp=%b", it, LOOP_ERR, exp_err); end
            checks++;
            if (RADDRI !== {exp_pc[PCW-2:0], 1'b0}) begin failures++; $display("FAIL rand%0d_pc got=%0h exp=%0h", it, RADDRI, {exp_pc[PCW-2:0], 1'b0}); end
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) busy_len[c] = 0;
        clear_mem();
        test_reset();
        test_drain();
        test_nonblocking();
        test_nested();
        test_zero_count();
        test_loop_err();
        test_purge_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loop_sequencer.md
Name: loop_sequencer

Overview:
Parametrised microcode sequencer, next generation of the accelerator's top-level instruction sequencer. Fetches instruction words from instruction SRAM and dispatches start requests to NCH compute/transfer engines. Stalls on engine busy, with optional non-blocking overlap. Adds hardware nested loops (LOOP_DEPTH-deep stack) and an incrementing/decrementing/loadable feature-SRAM address register.

Parameters:
IW, 256, instruction word width
PCW, 16, program counter width
NCH, 3, number of dispatch channels
LOOP_DEPTH, 3, loop stack entries
CW, 8, loop count / channel argument width
AW, 16, address register width

Ports:
CLK  in  1  clock
RSTL  in  1  asynchronous active-low reset
PURGE  in  1  synchronous clear, highest priority after reset
START  in  1  start program at pc=0; sampled only in IDLE
QI  in  IW  instruction read data, valid the cycle after RADDRI/RCEBI
RADDRI  out  PCW  instruction address, equal to {pc[PCW-2:0],1'b0}
RCEBI  out  1  instruction read enable, active-low
CH_REQ  out  NCH  one-cycle start pulse per channel
CH_ARG  out  CW  argument for requested channels
CH_BUSY  in  NCH  channel busy
RADDRX  out  AW  address register
SEQ_BUSY  out  1  high whenever state != IDLE
SEQ_FIN  out  1  one-cycle pulse on program end
LOOP_ERR  out  1  sticky loop stack error

Behaviour:
- Instruction fields: OP=QI[3:0]; ARG=QI[CW+3:4]; MASK=QI[CW+NCH+3:CW+4]; NB=QI[CW+NCH+4]; AMODE=QI[CW+NCH+6:CW+NCH+5]; AVAL=QI[AW+CW+NCH+6:CW+NCH+7].
- Opcodes: 0 NOP, 1 DISPATCH, 2 LOOP_BEGIN, 3 LOOP_END, 4 HALT. Others decode as NOP.
- States: IDLE, FETCH, EXEC, DRAIN, DONE.
- IDLE: RCEBI=1. START -> pc=0, go to FETCH.
- FETCH: RCEBI=0, RADDRI from pc. Go to EXEC. Minimum 2 cycles per instruction.
- EXEC decodes QI. The AMODE update applies once, in the cycle the instruction completes: 00 hold, 01 RADDRX+AVAL, 10 RADDRX-AVAL, 11 load AVAL. Arithmetic is modulo 2^AW.
- NOP: pc+1, go to FETCH.
- DISPATCH:
  - While (CH_BUSY&MASK)!=0, stay in EXEC with no request.
  - Else pulse CH_REQ=MASK and CH_ARG=ARG for 1 cycle.
  - NB=1: pc+1, go to FETCH.
  - NB=0: go to DRAIN.
  - MASK=0 behaves as NOP.
- DRAIN: first cycle is ignored, because channels raise busy the cycle after REQ. Then wait until (CH_BUSY&MASK_latched)==0, then pc+1, go to FETCH.
- LOOP_BEGIN: push {start=pc+1, count=max(ARG,1)}; pc+1.
- LOOP_END:
  - If top.count>1: decrement count, pc=top.start.
  - Else: pop, pc+1.
- HALT: go to DONE. DONE pulses SEQ_FIN=1 for 1 cycle, then IDLE. pc, RADDRX and LOOP_ERR are held.
- Errors (set LOOP_ERR, go to DONE): push when stack full; LOOP_END on empty stack.
- pc wraps from 2^PCW-1 to 0 without error.
- PURGE in any state, including mid-DRAIN: state=IDLE, pc=0, stack empty, RADDRX=0, CH_REQ=0, LOOP_ERR=0.
- START outside IDLE is ignored.
- Reset values: pc=0, state IDLE, RCEBI=1, RADDRI=0, CH_REQ=0, CH_ARG=0, RADDRX=0, SEQ_BUSY=0, SEQ_FIN=0, LOOP_ERR=0, stack empty.

Optional Feature:
SEQ_LOOP_ADDR_RESTORE_EN
- Defined: LOOP_BEGIN also stores RADDRX (after its own AMODE update) in the stack entry. LOOP_END with count>1 reloads RADDRX from that entry; the instruction's AMODE is ignored. On final iteration AMODE applies normally.
- Undefined: no address storage in the stack; LOOP_END always applies AMODE.

Test Plan:
- Program NOP, DISPATCH(MASK=001,ARG=5,NB=0), HALT; ch0 busy 4 cycles after REQ -> single CH_REQ=001, CH_ARG=5; FETCH of pc=2 only after busy falls; SEQ_FIN pulses once; SEQ_BUSY falls the next cycle.
- Two NB=1 DISPATCHes to ch0 then ch1; ch0 busy 10 cycles -> ch1 REQ issued while ch0 busy. A third DISPATCH to ch0 stalls in EXEC until ch0 busy drops.
- Nested LOOP_BEGIN(3), LOOP_BEGIN(2), DISPATCH(AMODE=01,AVAL=4), LOOP_END, LOOP_END, HALT -> 6 CH_REQ pulses; RADDRX=24 (feature off) / 4 (feature on).
- LOOP_BEGIN with ARG=0 -> body executes exactly once.
- Four LOOP_BEGINs with LOOP_DEPTH=3 -> LOOP_ERR=1, SEQ_FIN pulse. Separately, LOOP_END first -> LOOP_ERR=1.
- PURGE asserted in DRAIN while ch0 busy -> next cycle IDLE, pc=0, RADDRX=0, CH_REQ=0. START then reruns from pc=0.
